// File: rtl/uart_tx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_tx -- 8N1 UART transmitter.
//
// Serialises one byte per request: 1 start bit (low), 8 data bits LSB first,
// 1 stop bit (high), no parity. Each bit lasts CLKS_PER_BIT clock cycles,
// where CLKS_PER_BIT = clock frequency / baud rate (must be >= 2).
//
// Ports:
//   i_Clock     system clock, all state on the rising edge
//   i_Reset     asynchronous active-high reset
//   i_TX_DV     request strobe, only looked at while idle
//   i_TX_Byte   byte to send, captured on the accepting edge
//   o_TX_Serial serial line to the pin, idles high (registered)
//   o_TX_Active high from start bit through stop bit (registered)
//   o_TX_Done   one-cycle pulse after the stop bit completes (registered)
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Serial,
  output logic       o_TX_Active,
  output logic       o_TX_Done
);

  // Counter only ever needs to reach CLKS_PER_BIT-1.
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE         = 3'b000,
    TX_START_BIT = 3'b001,
    TX_DATA_BITS = 3'b010,
    TX_STOP_BIT  = 3'b011,
    CLEANUP      = 3'b100
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       byte_q, byte_d;
  logic             ser_q, ser_d;
  logic             act_q, act_d;
  logic             done_q, done_d;

  logic             bit_end;
  logic [2:0]       idx_inc;

  assign bit_end = (cnt_q == CNT_MAX);
  assign idx_inc = idx_q + 3'd1;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      ser_q   <= 1'b1;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      ser_q   <= ser_d;
      act_q   <= act_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. The outputs are computed one edge ahead so that the
  // next bit value appears on the same edge the counter wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    ser_d   = ser_q;
    act_d   = act_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        ser_d = 1'b1;
        cnt_d = '0;
        idx_d = '0;
        act_d = 1'b0;
        if (i_TX_DV) begin
          byte_d  = i_TX_Byte;
          ser_d   = 1'b0;
          act_d   = 1'b1;
          state_d = TX_START_BIT;
        end
      end

      TX_START_BIT: begin
        if (bit_end) begin
          cnt_d   = '0;
          ser_d   = byte_q[0];
          idx_d   = '0;
          state_d = TX_DATA_BITS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      TX_DATA_BITS: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            ser_d   = 1'b1;
            idx_d   = '0;
            state_d = TX_STOP_BIT;
          end else begin
            idx_d = idx_inc;
            ser_d = byte_q[idx_inc];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      TX_STOP_BIT: begin
        if (bit_end) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          act_d   = 1'b0;
          state_d = CLEANUP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      CLEANUP: begin
        ser_d   = 1'b1;
        state_d = IDLE;
      end

      default: begin
        ser_d   = 1'b1;
        act_d   = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign o_TX_Serial = ser_q;
  assign o_TX_Active = act_q;
  assign o_TX_Done   = done_q;

endmodule
